// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU.
// Returns {remainder, quotient} for HI/LO. All outputs are driven from flops,
// so the EX stall request built from ready_o has no combinational path from inputs.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  // dvd holds the dividend magnitude. Its MSB feeds each trial subtraction.
  // Quotient bits shift into its LSB, so after 32 steps it holds the quotient.
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] rem_q, rem_d;
  logic        neg1_q, neg1_d;
  logic        neg2_q, neg2_d;
  logic        sgn_q, sgn_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [32:0] trial;
  logic [31:0] q_fix, r_fix;

  // State and datapath registers; reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FREE;
      cnt_q    <= 6'd0;
      dvd_q    <= 32'd0;
      dvs_q    <= 32'd0;
      rem_q    <= 32'd0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      sgn_q    <= 1'b0;
      result_q <= 64'd0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      sgn_q    <= sgn_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FREE:   if (start_i && !annul_i) state_d = (opdata2_i == 32'd0) ? S_BYZERO : S_ON;
      S_BYZERO: state_d = S_END;
      S_ON:     if (annul_i) state_d = S_FREE;
                else if (cnt_q == 6'd32) state_d = S_END;
      S_END:    if (!start_i) state_d = S_FREE;
      default:  state_d = S_FREE;
    endcase
  end

  // Iteration datapath and registered outputs
  always_comb begin
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    sgn_d    = sgn_q;
    result_d = result_q;
    ready_d  = ready_q;

    trial = {rem_q, dvd_q[31]} - {1'b0, dvs_q};
    // Quotient is negative when signs differ. The remainder follows the dividend's sign.
    q_fix = (sgn_q && (neg1_q ^ neg2_q)) ? (32'd0 - dvd_q) : dvd_q;
    r_fix = (sgn_q && neg1_q) ? (32'd0 - rem_q) : rem_q;

    case (state_q)
      S_FREE: begin
        ready_d  = 1'b0;
        result_d = 64'd0;
        if (start_i && !annul_i && opdata2_i != 32'd0) begin
          dvd_d  = (signed_div_i && opdata1_i[31]) ? (32'd0 - opdata1_i) : opdata1_i;
          dvs_d  = (signed_div_i && opdata2_i[31]) ? (32'd0 - opdata2_i) : opdata2_i;
          neg1_d = opdata1_i[31];
          neg2_d = opdata2_i[31];
          sgn_d  = signed_div_i;
          rem_d  = 32'd0;
          cnt_d  = 6'd0;
        end
      end
      S_BYZERO: begin
        ready_d  = 1'b0;
        result_d = 64'd0;
      end
      S_ON: begin
        if (annul_i) begin
          ready_d  = 1'b0;
          result_d = 64'd0;
        end else if (cnt_q != 6'd32) begin
          rem_d = trial[32] ? {rem_q[30:0], dvd_q[31]} : trial[31:0];
          dvd_d = {dvd_q[30:0], ~trial[32]};
          cnt_d = cnt_q + 6'd1;
        end else begin
          // One extra cycle after the 32nd step applies the sign fix and presents the result
          result_d = {r_fix, q_fix};
          ready_d  = 1'b1;
        end
      end
      S_END: begin
        if (!start_i) begin
          ready_d  = 1'b0;
          result_d = 64'd0;
        end else begin
          // The divide-by-zero path reaches END with ready low and raises it here
          ready_d = 1'b1;
        end
      end
      default: begin
        ready_d  = 1'b0;
        result_d = 64'd0;
      end
    endcase
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = (state_q != S_FREE);

endmodule
